// File: rtl/elbeth_htif_mailbox.sv
// Host side of the to_host/from_host CSR mailbox: FWFT to_host FIFO (push visible next cycle) plus a one-word from_host holding register.
// Core stalls on tohost_full; host is throttled by h_tx_ready / h_rx_ready. Optional watchdog: ELBETH_HTIF_TIMEOUT_EN.
module elbeth_htif_mailbox #(
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tohost_wr_en,
  input  logic [31:0] tohost_wr_data,
  output logic        tohost_full,
  output logic [31:0] fromhost_data,
  output logic        fromhost_valid,
  input  logic        fromhost_clr,
  output logic        h_tx_valid,
  output logic [31:0] h_tx_data,
  input  logic        h_tx_ready,
  input  logic        h_rx_valid,
  input  logic [31:0] h_rx_data,
  output logic        h_rx_ready,
  output logic        test_done,
  output logic        test_pass,
  output logic [30:0] test_code,
  output logic        overflow
);

  localparam int            AW      = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end
  if (TIMEOUT_CYCLES < 32'd2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [30:0]   code_q, code_d;
  logic [31:0]   fh_data_q, fh_data_d;
  logic          fh_valid_q, fh_valid_d;
`ifdef ELBETH_HTIF_TIMEOUT_EN
  logic [31:0]   timer_q, timer_d;
`endif

  logic pop;
  logic push;
  logic status_hit;
  logic fh_accept;
  logic fh_clear;

  always_comb begin
    pop        = (count_q != '0) && h_tx_ready;
    // A full FIFO still takes a write when the host drains the head in the same cycle.
    push       = tohost_wr_en && ((count_q != DEPTH_C) || pop);
    status_hit = push && tohost_wr_data[0] && !done_q;
    fh_accept  = h_rx_valid && !fh_valid_q;
    fh_clear   = fromhost_clr && fh_valid_q;

    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    done_d     = done_q;
    pass_d     = pass_q;
    code_d     = code_q;
    fh_data_d  = fh_data_q;
    fh_valid_d = fh_valid_q;

    if (push) begin
      mem_d[wr_ptr_q] = tohost_wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    if (tohost_wr_en && !push) begin
      overflow_d = 1'b1;
    end

    if (status_hit) begin
      done_d = 1'b1;
      pass_d = (tohost_wr_data == 32'h1);
      code_d = tohost_wr_data[31:1];
    end

`ifdef ELBETH_HTIF_TIMEOUT_EN
    timer_d = timer_q;
    if (!done_q) begin
      timer_d = timer_q + 32'd1;
      // A real pass/fail word in the same cycle wins over the watchdog.
      if (!status_hit && timer_d == TIMEOUT_CYCLES - 32'd1) begin
        done_d = 1'b1;
        pass_d = 1'b0;
        code_d = 31'h7FFF_FFFF;
      end
    end
`endif

    if (fh_accept) begin
      fh_data_d  = h_rx_data;
      fh_valid_d = 1'b1;
    end else if (fh_clear) begin
      fh_data_d  = 32'h0;
      fh_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      code_q     <= 31'h0;
      fh_data_q  <= 32'h0;
      fh_valid_q <= 1'b0;
`ifdef ELBETH_HTIF_TIMEOUT_EN
      timer_q    <= 32'h0;
`endif
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      code_q     <= code_d;
      fh_data_q  <= fh_data_d;
      fh_valid_q <= fh_valid_d;
`ifdef ELBETH_HTIF_TIMEOUT_EN
      timer_q    <= timer_d;
`endif
    end
  end

  assign tohost_full    = (count_q == DEPTH_C);
  assign h_tx_valid     = (count_q != '0);
  assign h_tx_data      = mem_q[rd_ptr_q];
  assign fromhost_data  = fh_data_q;
  assign fromhost_valid = fh_valid_q;
  assign h_rx_ready     = !fh_valid_q;
  assign test_done      = done_q;
  assign test_pass      = pass_q;
  assign test_code      = code_q;
  assign overflow       = overflow_q;

endmodule
